// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the MEM-stage data memory responder.
// Imported by dmem_array and dmem_responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Word-index width for a storage array of the given depth.
  function automatic int DMEM_IDX_W(input int depth);
    return $clog2(depth);
  endfunction

  // Latency counter width; holds values 0..lat.
  function automatic int DMEM_CNT_W(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read/write-through port.
// Contents are never cleared; only the output register resets.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [2**IDX_W];
  logic [31:0] rdata_q;

  // Storage write; no reset so the array survives a pipeline reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Output register: stored word for writes, array word for reads.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage; stalls the pipeline
// until each access completes. Optional feature macro: DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        err_o,
`endif
  output logic        stall_o
);

  localparam int IDX_W = DMEM_IDX_W(DEPTH_WORDS);
  localparam int CNT_W = DMEM_CNT_W(LATENCY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               accept;
  logic               acc_en;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;
  logic               acc_err;
  logic               ram_we;
  logic [31:0]        ram_rdata;
  logic [IDX_W-1:0]   req_idx;

  assign req_idx     = req_addr_i[IDX_W+1:2];
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign accept      = req_valid_i & req_ready_o;
  assign stall_o     = req_valid_i & ~rsp_valid_o;

`ifdef DMEM_ALIGN_CHECK_EN
  logic req_err;
  logic err_q, err_d;
  logic rsp_err_q;

  assign req_err = (req_addr_i[1:0] != 2'b00) |
                   (req_addr_i[31:IDX_W+2] != '0);
  // Single-cycle accesses see the live request; longer ones the latch.
  assign acc_err = (state_q == IDLE) ? req_err : err_q;
  assign err_d   = accept ? req_err : err_q;
  assign ram_we  = acc_wr & ~acc_err;

  // Error flag of the pending request.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Error flag of the last completed access, held like the read data.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_err_q <= 1'b0;
    end else if (acc_en) begin
      rsp_err_q <= acc_err;
    end
  end

  assign err_o       = rsp_err_q;
  assign rsp_rdata_o = rsp_err_q ? 32'h0 : ram_rdata;
`else
  logic unused_addr_bits;

  assign unused_addr_bits = ^{req_addr_i[1:0], req_addr_i[31:IDX_W+2]};
  assign acc_err          = 1'b0;
  assign ram_we           = acc_wr & ~acc_err;
  assign rsp_rdata_o      = ram_rdata;
`endif

  // Next-state, request latch and access strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_wr    = wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write_i;
          idx_d   = req_idx;
          wdata_d = req_wdata_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            acc_en    = 1'b1;
            acc_wr    = req_write_i;
            acc_idx   = req_idx;
            acc_wdata = req_wdata_i;
            state_d   = RESP;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          acc_en  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  dmem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (acc_en & rst_n_i),
    .we_i    (ram_we),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

endmodule
